// File: rtl/validador_posicionamento.sv
// Piece-placement checker/committer owning both 8x8 boards; check and commit take one cycle per piece cell.
// No backpressure: requests arriving while ocupado=1 are dropped, and rd_cel/ocup_j* are always valid.
module validador_posicionamento #(
    parameter int N_CELULAS = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       valida,
    input  logic       grava,
    input  logic       limpa,
    input  logic [2:0] tipo,
    input  logic [3:0] X1,
    input  logic [3:0] Y1,
    input  logic       direcao,
    input  logic [2:0] orientacao,
    input  logic       jogador,
    input  logic       rd_jog,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic       conflito,
    output logic       pronto,
    output logic       ocupado,
    output logic       gravado,
    output logic       rd_cel,
    output logic [6:0] ocup_j0,
    output logic [6:0] ocup_j1
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]           state;
    logic [N_CELULAS-1:0] board0, board1;
    logic                 valida_q, result_ok, flag;
    logic [2:0]           tipo_q, ori_q, idx;
    logic [3:0]           x_q, y_q;
    logic                 dir_q, jog_q;

    logic                 start;
    logic [2:0]           len_m1;
    logic                 tipo_bad;
    logic [1:0]           ori_eff;
    logic signed [4:0]    dx, dy, cx, cy;
    logic                 oor, occ, cell_bad, last;
    logic [5:0]           cell_idx, rd_idx;
    logic                 rd_ok;

    assign start   = valida & ~valida_q & (state == IDLE);
    assign ocupado = (state != IDLE);

    always_comb begin
        len_m1 = 3'd0;
        case (tipo_q)
            3'd1:    len_m1 = 3'd1;
            3'd2:    len_m1 = 3'd2;
            3'd3:    len_m1 = 3'd3;
            3'd4:    len_m1 = 3'd4;
            default: len_m1 = 3'd0;
        endcase
    end

    assign tipo_bad = (tipo_q > 3'd4);
    assign ori_eff  = (ori_q == 3'd4) ? 2'd0 : ori_q[1:0];
    assign last     = (idx == len_m1);

    // Offset of cell idx from the anchor; hidroaviao uses a shape table, lines step along one axis.
    always_comb begin
        dx = 5'sd0;
        dy = 5'sd0;
        if (tipo_q == 3'd2) begin
            if (idx == 3'd1) begin
                case (ori_eff)
                    2'd0:    begin dx =  5'sd1; dy = -5'sd1; end
                    2'd1:    begin dx = -5'sd1; dy = -5'sd1; end
                    2'd2:    begin dx = -5'sd1; dy =  5'sd1; end
                    default: begin dx = -5'sd1; dy = -5'sd1; end
                endcase
            end else if (idx == 3'd2) begin
                case (ori_eff)
                    2'd0:    begin dx =  5'sd1; dy =  5'sd1; end
                    2'd1:    begin dx = -5'sd1; dy =  5'sd1; end
                    2'd2:    begin dx =  5'sd1; dy =  5'sd1; end
                    default: begin dx =  5'sd1; dy = -5'sd1; end
                endcase
            end
        end else if (dir_q) begin
            dy = $signed({2'b00, idx});
        end else begin
            dx = $signed({2'b00, idx});
        end
    end

    // Out-of-range anchors (including 0) wrap to values the range check always rejects.
    assign cx       = $signed({1'b0, x_q}) + dx;
    assign cy       = $signed({1'b0, y_q}) + dy;
    assign oor      = (cx < 5'sd1) || (cx > 5'sd8) || (cy < 5'sd1) || (cy > 5'sd8);
    assign cell_idx = {3'(cy[2:0] - 3'd1), 3'(cx[2:0] - 3'd1)};
    assign occ      = jog_q ? board1[cell_idx] : board0[cell_idx];
    assign cell_bad = tipo_bad | oor | occ;

    assign rd_ok  = (rd_x >= 4'd1) && (rd_x <= 4'd8) && (rd_y >= 4'd1) && (rd_y <= 4'd8);
    assign rd_idx = {3'(rd_y[2:0] - 3'd1), 3'(rd_x[2:0] - 3'd1)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            board0    <= '0;
            board1    <= '0;
            valida_q  <= 1'b0;
            result_ok <= 1'b0;
            flag      <= 1'b0;
            tipo_q    <= 3'd0;
            ori_q     <= 3'd0;
            idx       <= 3'd0;
            x_q       <= 4'd0;
            y_q       <= 4'd0;
            dir_q     <= 1'b0;
            jog_q     <= 1'b0;
            conflito  <= 1'b0;
            pronto    <= 1'b0;
            gravado   <= 1'b0;
            rd_cel    <= 1'b0;
            ocup_j0   <= 7'd0;
            ocup_j1   <= 7'd0;
        end else begin
            valida_q <= valida;
            pronto   <= 1'b0;
            gravado  <= 1'b0;
            rd_cel   <= rd_ok ? (rd_jog ? board1[rd_idx] : board0[rd_idx]) : 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        tipo_q    <= tipo;
                        x_q       <= X1;
                        y_q       <= Y1;
                        dir_q     <= direcao;
                        ori_q     <= orientacao;
                        jog_q     <= jogador;
                        idx       <= 3'd0;
                        flag      <= 1'b0;
                        result_ok <= 1'b0;
                        state     <= CHECK;
                    end else if (grava && result_ok) begin
                        idx   <= 3'd0;
                        state <= WRITE;
                    end else if (limpa) begin
                        board0    <= '0;
                        board1    <= '0;
                        ocup_j0   <= 7'd0;
                        ocup_j1   <= 7'd0;
                        result_ok <= 1'b0;
                    end
                end
                CHECK: begin
                    if (last) begin
                        conflito  <= flag | cell_bad;
                        result_ok <= ~(flag | cell_bad);
                        pronto    <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        flag <= flag | cell_bad;
                        idx  <= idx + 3'd1;
                    end
                end
                WRITE: begin
                    // Guarding on occ keeps the counter equal to the number of set cells.
                    if (!occ) begin
                        if (jog_q) begin
                            board1[cell_idx] <= 1'b1;
                            ocup_j1          <= ocup_j1 + 7'd1;
                        end else begin
                            board0[cell_idx] <= 1'b1;
                            ocup_j0          <= ocup_j0 + 7'd1;
                        end
                    end
                    if (last) begin
                        gravado   <= 1'b1;
                        result_ok <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
